alu_issue_stage: RTL and testbench

- Sequencing stage wrapped around the team's 8-bit combinational ALU (4-bit ctrl, x/y operands, carry/out results).
- Accepts one instruction per valid/ready handshake and reads operands from an internal 8x8 register file.
- Drives the ALU inputs from registers, captures the ALU result, then writes it back and reports it on a one-cycle writeback strobe.
- Both upstream operand/issue stage and downstream result/writeback stage of the ALU.

---
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue/writeback sequencer around an external 8-bit combinational ALU: IDLE -> EXEC -> WB.
// Optional macro ALU_STICKY_CARRY_EN adds a sticky carry flag output (carry_sticky).
module alu_issue_stage #(
  parameter int REG_DEPTH = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_imm_sel,
  input  logic [7:0]        in_imm,
  output logic [3:0]        alu_ctrl,
  output logic [7:0]        alu_x,
  output logic [7:0]        alu_y,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [7:0]        wb_data,
  output logic              wb_carry,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
`ifdef ALU_STICKY_CARRY_EN
  ,
  output logic              carry_sticky
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [3:0]          alu_ctrl_q, alu_ctrl_d;
  logic [7:0]          alu_x_q, alu_x_d;
  logic [7:0]          alu_y_q, alu_y_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic                wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [7:0]          wb_data_q, wb_data_d;
  logic                wb_carry_q, wb_carry_d;
  logic [7:0]          rf_q [REG_DEPTH];
  logic [7:0]          rf_d [REG_DEPTH];
  logic [REG_DEPTH-1:0] rf_we;

  // r0 has no write enable, so it stays at its reset value of zero.
  for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_we
    if (gi == 0) begin : g_r0
      assign rf_we[gi] = 1'b0;
    end else begin : g_rn
      assign rf_we[gi] = (state_q == WB) && (wb_addr_q == ADDR_W'(gi));
    end
  end

  always_comb begin
    for (int i = 0; i < REG_DEPTH; i++) begin
      rf_d[i] = rf_we[i] ? wb_data_q : rf_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_carry_d = wb_carry_q;
    in_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          alu_ctrl_d = in_op;
          alu_x_d    = rf_q[in_rs1];
          alu_y_d    = in_imm_sel ? in_imm : rf_q[in_rs2];
          rd_d       = in_rd;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // The writeback registers double as the result register.
        wb_valid_d = 1'b1;
        wb_addr_d  = rd_q;
        wb_data_d  = alu_out;
        wb_carry_d = alu_carry;
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_ctrl_q <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_carry_q <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_carry_q <= wb_carry_d;
      for (int i = 0; i < REG_DEPTH; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

`ifdef ALU_STICKY_CARRY_EN
  logic carry_sticky_q, carry_sticky_d;

  // Opcode 1111 clears the flag and wins over a simultaneous carry.
  always_comb begin
    carry_sticky_d = carry_sticky_q;
    if (state_q == WB) begin
      if (alu_ctrl_q == 4'b1111) begin
        carry_sticky_d = 1'b0;
      end else if (wb_carry_q) begin
        carry_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_sticky_q <= 1'b0;
    end else begin
      carry_sticky_q <= carry_sticky_d;
    end
  end

  assign carry_sticky = carry_sticky_q;
`endif

  assign alu_ctrl = alu_ctrl_q;
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_carry = wb_carry_q;
  assign dbg_data = (dbg_addr == '0) ? 8'h00 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: edge-counting reference model plus directed literal checks.
// Build with ALU_STICKY_CARRY_EN defined to also cover carry_sticky.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic       in_imm_sel;
  logic [7:0] in_imm;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       wb_carry;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
`ifdef ALU_STICKY_CARRY_EN
  logic       carry_sticky;
`endif

  always #5 clk = ~clk;

  alu_issue_stage #(.REG_DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_carry(wb_carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_STICKY_CARRY_EN
    , .carry_sticky(carry_sticky)
`endif
  );

  // Stand-in for the team ALU: returns {carry, out}.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      4'h0:    alu_f = {1'b0, x} + {1'b0, y};
      4'h1:    alu_f = {1'b0, x} - {1'b0, y};
      4'h2:    alu_f = {1'b0, x & y};
      4'h3:    alu_f = {1'b0, x | y};
      4'h4:    alu_f = {1'b0, ~x};
      4'h5:    alu_f = {1'b0, x ^ y};
      4'h6:    alu_f = {x[7], x[6:0], 1'b0};
      4'h7:    alu_f = {x[0], 1'b0, x[7:1]};
      4'h8:    alu_f = {1'b0, x} + 9'd1;
      4'h9:    alu_f = {1'b0, x} - 9'd1;
      4'hA:    alu_f = {1'b0, x};
      4'hB:    alu_f = {1'b0, y};
      4'hC:    alu_f = {1'b0, ~(x & y)};
      default: alu_f = 9'd0;
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_f(alu_ctrl, alu_x, alu_y);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (edge-indexed) ----------------
  int         edge_n = 0;
  int         ready_at = 0;
  int         wb_edge = 0;
  bit         model_live = 1'b0;
  bit         pend = 1'b0;
  logic [7:0] mrf [8];
  logic [2:0] p_rd;
  logic [7:0] p_data;
  logic       p_c;
  logic [3:0] p_op;
  logic       exp_wbv, exp_wbc, exp_sticky;
  logic [2:0] exp_wba;
  logic [7:0] exp_wbd, exp_x, exp_y;
  logic [3:0] exp_ctrl;
  int         wb_pulses = 0;

  always @(posedge clk) begin
    logic [7:0] mx, my;
    if (rst) begin
      for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
      pend = 1'b0;
      ready_at = edge_n + 1;
      exp_wbv = 0; exp_wba = 0; exp_wbd = 0; exp_wbc = 0;
      exp_ctrl = 0; exp_x = 0; exp_y = 0; exp_sticky = 0;
    end else begin
      exp_wbv = 1'b0;
      if (pend && edge_n == wb_edge) begin
        exp_wbv = 1'b1; exp_wba = p_rd; exp_wbd = p_data; exp_wbc = p_c;
      end else if (pend && edge_n == wb_edge + 1) begin
        if (p_rd != 3'd0) mrf[p_rd] = p_data;
        if (p_op == 4'hF) exp_sticky = 1'b0;
        else if (p_c) exp_sticky = 1'b1;
        pend = 1'b0;
      end
      if (edge_n >= ready_at && in_valid) begin
        mx = mrf[in_rs1];
        my = in_imm_sel ? in_imm : mrf[in_rs2];
        {p_c, p_data} = alu_f(in_op, mx, my);
        p_rd = in_rd; p_op = in_op; pend = 1'b1;
        wb_edge = edge_n + 1;
        ready_at = edge_n + 3;
        exp_ctrl = in_op; exp_x = mx; exp_y = my;
      end
    end
    model_live = 1'b1;
    edge_n++;
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("in_ready", in_ready, (edge_n >= ready_at));
      chk("wb_valid", wb_valid, exp_wbv);
      chk("wb_addr", wb_addr, exp_wba);
      chk("wb_data", wb_data, exp_wbd);
      chk("wb_carry", wb_carry, exp_wbc);
      chk("alu_ctrl", alu_ctrl, exp_ctrl);
      chk("alu_x", alu_x, exp_x);
      chk("alu_y", alu_y, exp_y);
      chk("dbg_data", dbg_data, mrf[dbg_addr]);
`ifdef ALU_STICKY_CARRY_EN
      chk("carry_sticky", carry_sticky, exp_sticky);
`endif
      if (wb_valid === 1'b1) wb_pulses++;
    end
  end

  bit rand_dbg = 1'b0;
  always @(posedge clk) if (rand_dbg) #1 dbg_addr = 3'($urandom_range(0, 7));

  // ---------------- directed helpers ----------------
  // Called at a negedge; returns at the negedge after acceptance with in_valid low.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic isel, input logic [7:0] imm,
                       output int acc);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm_sel = isel; in_imm = imm;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout: in_ready stayed %b, expected 1 within 20 cycles", in_ready);
    end
    acc = edge_n;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(input string nm, input int acc, input logic [2:0] a,
                         input logic [7:0] d, input logic c);
    int n = 0;
    while (wb_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_wb_seen"}, wb_valid, 1'b1);
    chk({nm, "_wb_latency"}, edge_n, acc + 2);
    chk({nm, "_wb_addr"}, wb_addr, a);
    chk({nm, "_wb_data"}, wb_data, d);
    chk({nm, "_wb_carry"}, wb_carry, c);
  endtask

  task automatic dbg_chk(input string nm, input logic [2:0] a, input logic [7:0] d);
    @(posedge clk);
    #1 dbg_addr = a;
    #1 chk(nm, dbg_data, d);
  endtask

  initial begin
    int a1, a2, p0;
    rst = 1'b1; in_valid = 1'b0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_imm_sel = 0; in_imm = 0; dbg_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_alu_ctrl", alu_ctrl, 4'h0);
    chk("reset_alu_x", alu_x, 8'h00);
    chk("reset_alu_y", alu_y, 8'h00);
    for (int i = 0; i < 8; i++) dbg_chk("reset_dbg", 3'(i), 8'h00);
    @(negedge clk);

    // Load r1 = 0x7F
    issue(4'h3, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, a1);
    wait_wb("load", a1, 3'd1, 8'h7F, 1'b0);
    dbg_chk("load_dbg_r1", 3'd1, 8'h7F);
    @(negedge clk);

    // Dependent ADDs, second issued right after the first's writeback
    issue(4'h0, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01, a1);
    wait_wb("add1", a1, 3'd2, 8'h80, 1'b0);
    issue(4'h0, 3'd3, 3'd2, 3'd2, 1'b0, 8'h00, a2);
    chk("raw_no_stall", a2, a1 + 3);
    wait_wb("add2", a2, 3'd3, 8'h00, 1'b1);
    @(negedge clk);
`ifdef ALU_STICKY_CARRY_EN
    chk("sticky_set", carry_sticky, 1'b1);
`endif

    // Back-pressure: two instructions back to back
    p0 = wb_pulses;
    issue(4'h5, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00, a1);
    chk("bp_busy_ready", in_ready, 1'b0);
    issue(4'h2, 3'd5, 3'd1, 3'd0, 1'b1, 8'h0F, a2);
    chk("bp_accept_gap", a2, a1 + 3);
    wait_wb("bp2", a2, 3'd5, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_pulses", wb_pulses - p0, 2);
    dbg_chk("bp_dbg_r4", 3'd4, 8'hFF);
    @(negedge clk);

    // Write to r0
    issue(4'h4, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, a1);
    wait_wb("r0", a1, 3'd0, 8'hFF, 1'b0);
    dbg_chk("r0_dbg", 3'd0, 8'h00);
    @(negedge clk);

    // Opcode 1111: out 0, clears sticky
    issue(4'hF, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00, a1);
    wait_wb("op15", a1, 3'd6, 8'h00, 1'b0);
    @(negedge clk);
`ifdef ALU_STICKY_CARRY_EN
    chk("sticky_clear", carry_sticky, 1'b0);
`endif

    // Reset during EXEC aborts the instruction
    issue(4'h0, 3'd7, 3'd1, 3'd0, 1'b1, 8'h01, a1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wb_valid", wb_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_wb_valid2", wb_valid, 1'b0);
    for (int i = 0; i < 8; i++) dbg_chk("abort_dbg", 3'(i), 8'h00);
    @(negedge clk);

    // Randomized traffic against the model
    rand_dbg = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), a1);
    end
    repeat (5) @(negedge clk);
    rand_dbg = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
